// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a circular FIFO of fetched {instr, pc} slots feeding one decode register.
// Supports bypass when the FIFO is empty, flush, decode stall and a sticky halt that blocks fetch.
module ifid_queue #(
    parameter int unsigned        DATA_W = 16,
    parameter int unsigned        DEPTH  = 4,
    parameter logic [DATA_W-1:0]  NOP    = DATA_W'(16'b0000100000000000),
    parameter logic [DATA_W-1:0]  HALT   = DATA_W'(16'b0)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [DATA_W-1:0]        fetch_instr,
    input  logic [DATA_W-1:0]        fetch_pc,
    input  logic                     fetch_halt,
    input  logic                     flush,
    input  logic                     dec_stall,
    output logic                     fetch_ready,
    output logic [DATA_W-1:0]        IFID_instr,
    output logic [DATA_W-1:0]        IFID_PC,
    output logic                     IFID_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
    } slot_t;

    slot_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;
    logic [DATA_W-1:0]  ifid_instr_q, ifid_instr_d;
    logic [DATA_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    slot_t              fetch_slot;
    slot_t              head_slot;

    assign fetch_ready = (count_q < CNT_W'(DEPTH)) && !halted_q;
    assign fifo_empty  = (count_q == '0);
    assign head_slot   = mem_q[rd_ptr_q];

    // Queue and decode-register next state; flush overrides stall and fetch.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        halted_d     = halted_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        push         = 1'b0;
        pop          = 1'b0;

        accept           = fetch_valid && fetch_ready && !flush;
        fetch_slot.instr = fetch_halt ? HALT : fetch_instr;
        fetch_slot.pc    = fetch_pc;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            halted_d     = 1'b0;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end else begin
            if (accept && fetch_halt) begin
                halted_d = 1'b1;
            end
            if (dec_stall) begin
                push = accept;
            end else if (!fifo_empty) begin
                pop          = 1'b1;
                push         = accept;
                ifid_instr_d = head_slot.instr;
                ifid_pc_d    = head_slot.pc;
                ifid_valid_d = 1'b1;
            end else if (accept) begin
                ifid_instr_d = fetch_slot.instr;
                ifid_pc_d    = fetch_slot.pc;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = NOP;
                ifid_valid_d = 1'b0;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            halted_q     <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            halted_q     <= halted_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fetch_slot;
        end
    end

    assign IFID_instr = ifid_instr_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_valid = ifid_valid_q;
    assign count      = count_q;

endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_ifid_queue;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam logic [15:0] NOP    = 16'h0800;
    localparam logic [15:0] HALT   = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc;
    logic        fetch_halt;
    logic        flush;
    logic        dec_stall;
    logic        fetch_ready;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_PC;
    logic        IFID_valid;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    // Model state: items inside the FIFO, the expected decode register, and the delivery scoreboard.
    slot_t       m_fifo[$];
    slot_t       exp_q[$];
    logic        m_halted;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        load_pending;

    ifid_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .NOP   (NOP),
        .HALT  (HALT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_pc   (fetch_pc),
        .fetch_halt (fetch_halt),
        .flush      (flush),
        .dec_stall  (dec_stall),
        .fetch_ready(fetch_ready),
        .IFID_instr (IFID_instr),
        .IFID_PC    (IFID_PC),
        .IFID_valid (IFID_valid),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_halted = 1'b0;
        e_valid  = 1'b0;
        e_instr  = NOP;
        e_pc     = 16'h0000;
    endtask

    task automatic check_outputs();
        chk("fetch_ready", 32'(fetch_ready), 32'((m_fifo.size() < DEPTH) && !m_halted));
        chk("count",       32'(count),       32'(m_fifo.size()));
        chk("IFID_valid",  32'(IFID_valid),  32'(e_valid));
        chk("IFID_instr",  32'(IFID_instr),  32'(e_instr));
        chk("IFID_PC",     32'(IFID_PC),     32'(e_pc));
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0;
        fetch_instr = 16'h0000;
        fetch_pc    = 16'h0000;
        fetch_halt  = 1'b0;
        flush       = 1'b0;
        dec_stall   = 1'b0;
    endtask

    // One cycle: check the previous cycle's prediction, drive new inputs, advance the model.
    task automatic step(input logic fv, input logic [15:0] fi, input logic [15:0] fp,
                        input logic fh, input logic fl, input logic st);
        logic  ready;
        slot_t s;
        @(negedge clk);
        check_outputs();
        #1;
        fetch_valid = fv;
        fetch_instr = fi;
        fetch_pc    = fp;
        fetch_halt  = fh;
        flush       = fl;
        dec_stall   = st;
        ready = (m_fifo.size() < DEPTH) && !m_halted;
        if (fl) begin
            m_fifo.delete();
            exp_q.delete();
            m_halted = 1'b0;
            e_valid  = 1'b0;
            e_instr  = NOP;
        end else begin
            if (fv && ready) begin
                s.instr = fh ? HALT : fi;
                s.pc    = fp;
                m_fifo.push_back(s);
                exp_q.push_back(s);
                if (fh) m_halted = 1'b1;
            end
            if (!st) begin
                if (m_fifo.size() > 0) begin
                    s       = m_fifo.pop_front();
                    e_instr = s.instr;
                    e_pc    = s.pc;
                    e_valid = 1'b1;
                end else begin
                    e_instr = NOP;
                    e_valid = 1'b0;
                end
            end
        end
    endtask

    // Monitor: note whether the decode register loaded at this edge.
    always @(posedge clk) begin
        load_pending = !rst && !flush && !dec_stall;
    end

    // Monitor: each real decode-stage instruction must match the oldest undelivered fetch.
    initial begin
        slot_t s;
        load_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (load_pending && !rst) begin
                if (IFID_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected actual=%h/%h expected=none at %0t", IFID_instr, IFID_PC, $time);
                    end else begin
                        s = exp_q.pop_front();
                        chk("sb_order", {IFID_instr, IFID_PC}, {s.instr, s.pc});
                    end
                end else begin
                    chk("sb_missing", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(IFID_valid), 32'd0);
        chk("reset_instr", 32'(IFID_instr), 32'(NOP));
        chk("reset_ready", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;

        // Bypass from empty queue.
        step(1'b1, 16'hA123, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Fill under stall; the fifth fetch is refused.
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h1000 + 16'(i), 16'h0010 + 16'(2*i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Flush wins over stall with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h2000 + 16'(i), 16'h0020 + 16'(2*i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h2FFF, 16'h002E, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Halt blocks fetch until flush.
        step(1'b1, 16'h3333, 16'h0030, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h3400 + 16'(i), 16'h0032, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h3500, 16'h0034, 1'b0, 1'b0, 1'b0);

        // Randomized traffic exercising pointer wrap, stalls, flushes and halts.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) == 0);

        // Asynchronous reset between edges with two entries queued.
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h4000, 16'h0040, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h4001, 16'h0042, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outputs();
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_valid", 32'(IFID_valid), 32'd0);
        chk("async_instr", 32'(IFID_instr), 32'(NOP));
        chk("async_pc",    32'(IFID_PC), 32'd0);
        chk("async_ready", 32'(fetch_ready), 32'd1);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        step(1'b1, 16'h5555, 16'h0050, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 Parameter DATA_W, default 16: instruction and PC width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries behind the decode register; power of two, at least 2.
REQ-003 Parameter NOP, default 16'b0000100000000000: bubble encoding.
REQ-004 Parameter HALT, default 16'b0: halt encoding.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fetch_valid  input  1  IF presents an instruction this cycle (low during an IMem stall).
REQ-008 fetch_instr  input  DATA_W  fetched instruction.
REQ-009 fetch_pc  input  DATA_W  PC+2 of the fetched instruction.
REQ-010 fetch_halt  input  1  DMem dump or error: the fetched slot is replaced by HALT.
REQ-011 flush  input  1  squash all queued and decode-stage instructions.
REQ-012 dec_stall  input  1  DMem or hazard stall; the decode register must hold.
REQ-013 fetch_ready  output  1  the queue accepts a fetch this cycle.
REQ-014 IFID_instr  output  DATA_W  instruction in the decode stage.
REQ-015 IFID_PC  output  DATA_W  PC+2 of the decode-stage instruction.
REQ-016 IFID_valid  output  1  the decode stage holds a real instruction, not a bubble.
REQ-017 count  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the decode register.

Function
REQ-018 Storage SHALL be a DEPTH-entry circular FIFO of {instr, pc}, followed by one decode register that drives IFID_*.
REQ-019 Fetch acceptance SHALL be: accept = fetch_valid & fetch_ready & !flush.
REQ-020 An accepted slot SHALL carry HALT when fetch_halt is high, and fetch_instr otherwise; pc SHALL be fetch_pc in both cases.
REQ-021 fetch_ready SHALL equal (count < DEPTH) & !halted, combinationally.
REQ-022 halted SHALL be internal state, set when a slot with fetch_halt is accepted and cleared only by flush or rst.
REQ-023 Flush SHALL take priority over every other event, including dec_stall.
REQ-024 On flush the next cycle SHALL have count=0, IFID_instr=NOP, IFID_valid=0, IFID_PC held, and halted=0; a same-cycle fetch SHALL be discarded.
REQ-025 When dec_stall=1 and flush=0, the decode register SHALL hold all of its values.
REQ-026 When dec_stall=1 and flush=0, the FIFO SHALL still enqueue an accepted fetch.
REQ-027 When dec_stall=0 and flush=0 with the FIFO nonempty, the decode register SHALL load the FIFO head with IFID_valid=1 and the head SHALL pop.
REQ-028 When dec_stall=0 and flush=0 with the FIFO empty and accept=1, the fetched slot SHALL bypass the FIFO straight into the decode register with IFID_valid=1; count SHALL be unchanged.
REQ-029 When dec_stall=0 and flush=0 with the FIFO empty and accept=0, the decode register SHALL load NOP with IFID_valid=0, and IFID_PC SHALL hold.
REQ-030 Simultaneous pop and push SHALL leave count unchanged and preserve order; a push at count=DEPTH is impossible because fetch_ready=0.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-032 Latency SHALL be one cycle from fetch to IFID_* when the FIFO is empty and dec_stall=0; FIFO order SHALL be strictly preserved.

Reset
REQ-033 Asserting rst SHALL immediately, without waiting for a clock edge, set both FIFO pointers to 0, count=0, halted=0, IFID_instr=NOP, IFID_PC=0, IFID_valid=0, and fetch_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; the first edge after rst deasserts SHALL behave as from an empty queue.

Verification
REQ-035 Bypass: after reset, drive fetch_valid=1, fetch_instr=16'hA123, fetch_pc=16'h0002 with dec_stall=0 -> next cycle IFID_instr=A123, IFID_PC=0002, IFID_valid=1, count=0.
REQ-036 Fill: hold dec_stall=1 while fetching 5 instructions (DEPTH=4) -> count reaches 4, fetch_ready=0, and the 5th instruction is not accepted; release the stall -> decode receives the instructions in order, one per cycle.
REQ-037 Flush over stall: with count=3 and dec_stall=1, assert flush with fetch_valid=1 -> next cycle count=0, IFID_instr=0800, IFID_valid=0, and the fetched instruction is lost.
REQ-038 Halt: fetch with fetch_halt=1 -> a HALT (16'h0000) slot is queued and fetch_ready=0 thereafter; subsequent fetch_valid is ignored until flush, after which fetch_ready=1.
REQ-039 Wrap: run 3*DEPTH fetches interleaved with random dec_stall -> the decode order matches the fetch order, and count stays within 0..4 throughout.
REQ-040 Async reset: assert rst between clock edges with count=2 -> outputs take their reset values before the next clock edge.
